// File: rtl/morse_defs.sv
// ---------------------------------------------------------------------------
// morse_defs
// Shared definitions for the Morse sequence decoder:
//   - 2-bit symbol codes used inside each 10-bit slot
//   - FSM state encoding
//   - ASCII constants for word space, unknown character and "no character"
//   - slot geometry and a helper that selects one slot from the batch word
// ---------------------------------------------------------------------------
package morse_defs;

  // Symbol codes; the first symbol of a slot sits in bits [9:8].
  localparam logic [1:0] SYM_NONE  = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_DASH  = 2'b10;
  localparam logic [1:0] SYM_SPACE = 2'b11;

  // Slot geometry.
  localparam int unsigned SLOT_W    = 10;
  localparam int unsigned BATCH_W   = 30;
  localparam logic [1:0]  LAST_SLOT = 2'd2;

  // ASCII constants.
  localparam logic [7:0] ASCII_NUL     = 8'h00;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Select slot idx from a captured batch; slot0 is the most significant
  // field because it was entered first. Index 3 is unreachable and maps to
  // the last slot so the selection is total.
  function automatic logic [SLOT_W-1:0] get_slot(
    input logic [BATCH_W-1:0] seqs,
    input logic [1:0]         idx
  );
    logic [SLOT_W-1:0] slot_v;
    case (idx)
      2'd0:    slot_v = seqs[29:20];
      2'd1:    slot_v = seqs[19:10];
      default: slot_v = seqs[9:0];
    endcase
    return slot_v;
  endfunction

endpackage : morse_defs

// File: rtl/morse_lut.sv
// ---------------------------------------------------------------------------
// morse_lut
// Purely combinational International Morse code table.
// Ports:
//   slot  in  10  five 2-bit symbols, first symbol in [9:8]
//   ascii out 8   decoded character (A-Z, 0-9, space) or '?' when the slot
//                 is malformed or has no table entry
//   empty out 1   slot is all zero and must be skipped
// Because every well-formed code is a dot/dash run padded with 00, matching
// the full 10-bit pattern also rejects malformed slots: anything not listed
// falls to the '?' default.
// ---------------------------------------------------------------------------
module morse_lut
  import morse_defs::*;
(
  input  logic [9:0] slot,
  output logic [7:0] ascii,
  output logic       empty
);

  // Empty detection is independent of the table lookup.
  always_comb begin
    empty = (slot == 10'b00_00_00_00_00);
  end

  // Code table: dot=01, dash=10, padding=00.
  always_comb begin
    case (slot)
      10'b00_00_00_00_00: ascii = ASCII_NUL;
      10'b11_00_00_00_00: ascii = ASCII_SPACE;
      10'b01_10_00_00_00: ascii = 8'h41; // A .-
      10'b10_01_01_01_00: ascii = 8'h42; // B -...
      10'b10_01_10_01_00: ascii = 8'h43; // C -.-.
      10'b10_01_01_00_00: ascii = 8'h44; // D -..
      10'b01_00_00_00_00: ascii = 8'h45; // E .
      10'b01_01_10_01_00: ascii = 8'h46; // F ..-.
      10'b10_10_01_00_00: ascii = 8'h47; // G --.
      10'b01_01_01_01_00: ascii = 8'h48; // H ....
      10'b01_01_00_00_00: ascii = 8'h49; // I ..
      10'b01_10_10_10_00: ascii = 8'h4A; // J .---
      10'b10_01_10_00_00: ascii = 8'h4B; // K -.-
      10'b01_10_01_01_00: ascii = 8'h4C; // L .-..
      10'b10_10_00_00_00: ascii = 8'h4D; // M --
      10'b10_01_00_00_00: ascii = 8'h4E; // N -.
      10'b10_10_10_00_00: ascii = 8'h4F; // O ---
      10'b01_10_10_01_00: ascii = 8'h50; // P .--.
      10'b10_10_01_10_00: ascii = 8'h51; // Q --.-
      10'b01_10_01_00_00: ascii = 8'h52; // R .-.
      10'b01_01_01_00_00: ascii = 8'h53; // S ...
      10'b10_00_00_00_00: ascii = 8'h54; // T -
      10'b01_01_10_00_00: ascii = 8'h55; // U ..-
      10'b01_01_01_10_00: ascii = 8'h56; // V ...-
      10'b01_10_10_00_00: ascii = 8'h57; // W .--
      10'b10_01_01_10_00: ascii = 8'h58; // X -..-
      10'b10_01_10_10_00: ascii = 8'h59; // Y -.--
      10'b10_10_01_01_00: ascii = 8'h5A; // Z --..
      10'b10_10_10_10_10: ascii = 8'h30; // 0 -----
      10'b01_10_10_10_10: ascii = 8'h31; // 1 .----
      10'b01_01_10_10_10: ascii = 8'h32; // 2 ..---
      10'b01_01_01_10_10: ascii = 8'h33; // 3 ...--
      10'b01_01_01_01_10: ascii = 8'h34; // 4 ....-
      10'b01_01_01_01_01: ascii = 8'h35; // 5 .....
      10'b10_01_01_01_01: ascii = 8'h36; // 6 -....
      10'b10_10_01_01_01: ascii = 8'h37; // 7 --...
      10'b10_10_10_01_01: ascii = 8'h38; // 8 ---..
      10'b10_10_10_10_01: ascii = 8'h39; // 9 ----.
      default:            ascii = ASCII_UNKNOWN;
    endcase
  end

endmodule : morse_lut

// File: rtl/morse_seq_decoder.sv
// ---------------------------------------------------------------------------
// morse_seq_decoder
// Captures a batch of three Morse slots and emits one ASCII character per
// non-empty slot through a valid/ready handshake, then pulses done.
// Ports:
//   clk          in  1   system clock, rising edge
//   Reset        in  1   synchronous active-high reset
//   store_seqs   in  30  slot0=[29:20] (first), slot1=[19:10], slot2=[9:0]
//   storageSent  in  1   store_seqs valid this cycle
//   char_ready   in  1   consumer accepts char_out this cycle
//   char_out     out 8   decoded character, 0x00 whenever char_valid=0
//   char_valid   out 1   char_out valid, held until accepted
//   busy         out 1   a captured batch is being processed
//   done         out 1   one-cycle pulse after the last slot of a batch
//   dropped      out 1   one-cycle pulse when storageSent arrived while busy
// All outputs come straight from flops; the output-logic process computes
// their next values from the current state.
// ---------------------------------------------------------------------------
module morse_seq_decoder
  import morse_defs::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic [29:0] store_seqs,
  input  logic        storageSent,
  input  logic        char_ready,
  output logic [7:0]  char_out,
  output logic        char_valid,
  output logic        busy,
  output logic        done,
  output logic        dropped
);

  state_t      state_r;
  state_t      state_s;

  logic [29:0] seqs_r;
  logic [29:0] seqs_s;
  logic [1:0]  idx_r;
  logic [1:0]  idx_s;

  logic [7:0]  char_out_r;
  logic [7:0]  char_out_s;
  logic        char_valid_r;
  logic        char_valid_s;
  logic        busy_r;
  logic        busy_s;
  logic        done_r;
  logic        done_s;
  logic        dropped_r;
  logic        dropped_s;

  logic [9:0]  cur_slot_s;
  logic [7:0]  lut_char_s;
  logic        lut_empty_s;
  logic        handshake_s;

  // Current slot selection and handshake qualification.
  always_comb begin
    cur_slot_s  = get_slot(seqs_r, idx_r);
    handshake_s = char_valid_r && char_ready;
  end

  morse_lut u_lut (
    .slot  (cur_slot_s),
    .ascii (lut_char_s),
    .empty (lut_empty_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (storageSent) begin
          state_s = ST_LOOKUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (!lut_empty_s) begin
          state_s = ST_EMIT;
        end else if (idx_r == LAST_SLOT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOOKUP;
        end
      end
      ST_EMIT: begin
        if (!handshake_s) begin
          state_s = ST_EMIT;
        end else if (idx_r == LAST_SLOT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOOKUP;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next-value logic.
  always_comb begin
    seqs_s       = seqs_r;
    idx_s        = idx_r;
    char_out_s   = ASCII_NUL;
    char_valid_s = 1'b0;
    done_s       = 1'b0;
    busy_s       = (state_s != ST_IDLE);
    // A request that arrives while a batch is in flight is refused, not queued.
    dropped_s    = storageSent && (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (storageSent) begin
          seqs_s = store_seqs;
          idx_s  = 2'd0;
        end else begin
          seqs_s = seqs_r;
        end
      end
      ST_LOOKUP: begin
        if (!lut_empty_s) begin
          char_out_s   = lut_char_s;
          char_valid_s = 1'b1;
        end else if (idx_r == LAST_SLOT) begin
          // Index saturates at the last slot instead of wrapping.
          done_s = 1'b1;
        end else begin
          idx_s = idx_r + 2'd1;
        end
      end
      ST_EMIT: begin
        if (!handshake_s) begin
          char_out_s   = char_out_r;
          char_valid_s = 1'b1;
        end else if (idx_r == LAST_SLOT) begin
          done_s = 1'b1;
        end else begin
          idx_s = idx_r + 2'd1;
        end
      end
      ST_DONE: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      seqs_r       <= 30'd0;
      idx_r        <= 2'd0;
      char_out_r   <= ASCII_NUL;
      char_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      dropped_r    <= 1'b0;
    end else begin
      seqs_r       <= seqs_s;
      idx_r        <= idx_s;
      char_out_r   <= char_out_s;
      char_valid_r <= char_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      dropped_r    <= dropped_s;
    end
  end

  assign char_out   = char_out_r;
  assign char_valid = char_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign dropped    = dropped_r;

endmodule : morse_seq_decoder

// File: tb/tb_morse_seq_decoder.sv
// ---------------------------------------------------------------------------
// tb_morse_seq_decoder
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based behavioural model that decodes slots via a Morse string table.
// ---------------------------------------------------------------------------
module tb_morse_seq_decoder;

  logic        clk = 1'b0;
  logic        Reset;
  logic [29:0] store_seqs;
  logic        storageSent;
  logic        char_ready;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        busy;
  logic        done;
  logic        dropped;

  always #5 clk = ~clk;

  morse_seq_decoder dut (
    .clk         (clk),
    .Reset       (Reset),
    .store_seqs  (store_seqs),
    .storageSent (storageSent),
    .char_ready  (char_ready),
    .char_out    (char_out),
    .char_valid  (char_valid),
    .busy        (busy),
    .done        (done),
    .dropped     (dropped)
  );

  int total = 0;
  int bad   = 0;

  string tab_code[36];
  string tab_chr = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  // Model state: outputs expected in the current cycle plus the slots still
  // to be processed for the batch in flight.
  bit         m_busy = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_done = 1'b0;
  bit         m_dropped = 1'b0;
  bit         m_pend = 1'b0;
  logic [7:0] m_char = 8'h00;
  logic [9:0] m_q[$];
  bit         model_known = 1'b0;

  logic [7:0] got_q[$];
  int         done_cnt = 0;
  int         valid_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode by turning the slot into a dot/dash string and searching the table.
  function automatic logic [7:0] model_decode(input logic [9:0] slot);
    string s = "";
    bit    seen_none = 1'b0;
    bit    ok = 1'b1;
    logic [1:0] sym;
    if (slot == 10'h000) return 8'h00;
    if (slot == 10'b1100000000) return 8'h20;
    for (int i = 0; i < 5; i++) begin
      sym = slot[9-2*i -: 2];
      if (sym == 2'b01) begin
        if (seen_none) ok = 1'b0;
        s = {s, "."};
      end else if (sym == 2'b10) begin
        if (seen_none) ok = 1'b0;
        s = {s, "-"};
      end else if (sym == 2'b00) begin
        seen_none = 1'b1;
      end else begin
        ok = 1'b0;
      end
    end
    if (!ok) return 8'h3F;
    for (int i = 0; i < 36; i++) begin
      if (tab_code[i] == s) return tab_chr[i];
    end
    return 8'h3F;
  endfunction

  function automatic logic [9:0] encode(input string s);
    logic [9:0] v = 10'h000;
    for (int i = 0; i < s.len(); i++) begin
      v[9-2*i -: 2] = (s[i] == 8'h2E) ? 2'b01 : 2'b10;
    end
    return v;
  endfunction

  function automatic logic [9:0] gen_slot();
    int r = $urandom_range(0, 9);
    if (r == 0) return 10'h000;
    if (r == 1) return 10'b1100000000;
    if (r == 2) return 10'($urandom_range(0, 1023));
    return encode(tab_code[$urandom_range(0, 35)]);
  endfunction

  task automatic model_step();
    logic [9:0] sl;
    bit drop_n;
    if (Reset) begin
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_dropped = 1'b0;
      m_pend = 1'b0; m_char = 8'h00; m_q.delete(); model_known = 1'b1;
    end else begin
      drop_n = storageSent && m_busy;
      if (!m_busy) begin
        if (storageSent) begin
          m_q.delete();
          m_q.push_back(store_seqs[29:20]);
          m_q.push_back(store_seqs[19:10]);
          m_q.push_back(store_seqs[9:0]);
          m_pend = 1'b1;
          m_busy = 1'b1;
        end
      end else if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_valid) begin
        if (char_ready) begin
          m_valid = 1'b0;
          m_char  = 8'h00;
          if (m_q.size() == 0) m_done = 1'b1;
          else m_pend = 1'b1;
        end
      end else if (m_pend) begin
        sl = m_q.pop_front();
        m_pend = 1'b0;
        if (sl == 10'h000) begin
          if (m_q.size() == 0) m_done = 1'b1;
          else m_pend = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_char  = model_decode(sl);
        end
      end
      m_dropped = drop_n;
    end
  endtask

  task automatic compare_all();
    if (model_known) begin
      chk("char_valid", char_valid, m_valid);
      chk("char_out", char_out, m_char);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("dropped", dropped, m_dropped);
    end
  endtask

  // One clock: log handshakes seen this cycle, step model at the edge,
  // compare on the falling edge.
  task automatic cycle();
    if (char_valid === 1'b1 && char_ready === 1'b1) got_q.push_back(char_out);
    if (char_valid === 1'b1) valid_cnt++;
    if (done === 1'b1) done_cnt++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic start_batch(input logic [29:0] s);
    got_q.delete();
    store_seqs  = s;
    storageSent = 1'b1;
    cycle();
    storageSent = 1'b0;
  endtask

  task automatic finish_batch(input int bound);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < bound) begin
      cycle();
      n++;
    end
    chk("batch_timeout", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic check_got(input string nm, input int n, input logic [7:0] c0,
                           input logic [7:0] c1, input logic [7:0] c2);
    logic [7:0] e[3];
    e[0] = c0; e[1] = c1; e[2] = c2;
    chk({nm, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      chk($sformatf("%s_char%0d", nm, i), got_q[i], e[i]);
    end
  endtask

  localparam logic [9:0] S_C = 10'b0101010000;
  localparam logic [9:0] O_C = 10'b1010100000;

  initial begin
    int d0;
    tab_code = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                 ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                 "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                 "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                 "--...", "---..", "----."};
    Reset = 1'b1; storageSent = 1'b0; char_ready = 1'b1; store_seqs = 30'd0;
    cycle(); cycle();
    Reset = 1'b0;
    cycle();
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", char_valid, 1'b0);
    chk("reset_char", char_out, 8'h00);

    // Pin the model's table against hand-known codes.
    chk("pin_S", model_decode(S_C), 8'h53);
    chk("pin_O", model_decode(O_C), 8'h4F);
    chk("pin_5", model_decode(10'b0101010101), 8'h35);
    chk("pin_space", model_decode(10'b1100000000), 8'h20);
    chk("pin_malformed", model_decode(10'b0100010000), 8'h3F);
    chk("pin_Q", model_decode(10'b1010011000), 8'h51);

    // SOS with latency pins.
    char_ready = 1'b1;
    start_batch({S_C, O_C, S_C});
    chk("sos_busy_n1", busy, 1'b1);
    chk("sos_valid_n1", char_valid, 1'b0);
    cycle();
    chk("sos_valid_n2", char_valid, 1'b1);
    chk("sos_char_n2", char_out, 8'h53);
    finish_batch(50);
    check_got("sos", 3, 8'h53, 8'h4F, 8'h53);

    // Backpressure during the first character.
    char_ready = 1'b0;
    start_batch({S_C, O_C, S_C});
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", char_valid, 1'b1);
      chk("bp_char", char_out, 8'h53);
      cycle();
    end
    char_ready = 1'b1;
    finish_batch(50);
    check_got("bp", 3, 8'h53, 8'h4F, 8'h53);

    // Mixed batches: empty + space + digit, malformed + letters.
    start_batch({10'b0000000000, 10'b1100000000, 10'b0101010101});
    finish_batch(50);
    check_got("mix1", 2, 8'h20, 8'h35, 8'h00);
    start_batch({10'b0100010000, 10'b0110000000, 10'b0100000000});
    finish_batch(50);
    check_got("mix2", 3, 8'h3F, 8'h41, 8'h45);

    // Collision while busy.
    start_batch({S_C, O_C, S_C});
    cycle();
    storageSent = 1'b1;
    store_seqs  = {3{10'b1010000000}};
    cycle();
    storageSent = 1'b0;
    chk("drop_pulse", dropped, 1'b1);
    finish_batch(50);
    check_got("collide", 3, 8'h53, 8'h4F, 8'h53);

    // Reset during EMIT discards the batch.
    char_ready = 1'b0;
    start_batch({S_C, O_C, S_C});
    cycle();
    chk("rst_emit_valid_before", char_valid, 1'b1);
    d0 = done_cnt;
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    chk("rst_emit_valid", char_valid, 1'b0);
    chk("rst_emit_busy", busy, 1'b0);
    chk("rst_emit_char", char_out, 8'h00);
    char_ready = 1'b1;
    repeat (6) cycle();
    chk("rst_emit_no_done", done_cnt, d0);

    // All-empty batch timing.
    valid_cnt = 0;
    start_batch(30'd0);
    chk("empty_busy_n1", busy, 1'b1);
    chk("empty_done_n1", done, 1'b0);
    cycle();
    chk("empty_busy_n2", busy, 1'b1);
    cycle();
    chk("empty_busy_n3", busy, 1'b1);
    chk("empty_done_n3", done, 1'b0);
    cycle();
    chk("empty_busy_n4", busy, 1'b1);
    chk("empty_done_n4", done, 1'b1);
    cycle();
    chk("empty_busy_n5", busy, 1'b0);
    chk("empty_done_n5", done, 1'b0);
    chk("empty_no_valid", valid_cnt, 0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 299) == 0);
      storageSent = ($urandom_range(0, 5) == 0);
      store_seqs  = {gen_slot(), gen_slot(), gen_slot()};
      char_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    Reset = 1'b0; storageSent = 1'b0; char_ready = 1'b1;
    repeat (20) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_morse_seq_decoder
